// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants and dump FSM state type for the
//               multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_dump_ctrl
// Description : Register dump sequencer. Walks every register index once,
//               capturing one value per beat and presenting it on a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_dump_ctrl
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_dump_req,
  input  logic            i_dump_ready,
  input  logic [XLEN-1:0] i_cap_data,
  output logic [AW-1:0]   o_cnt,
  output logic            o_dump_busy,
  output logic            o_dump_valid,
  output logic            o_dump_last,
  output logic [AW-1:0]   o_dump_idx,
  output logic [XLEN-1:0] o_dump_data
);

  localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

  dump_state_t     r_state;
  dump_state_t     w_next;
  logic            w_accept;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_data;
  logic            r_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; requests outside IDLE are dropped, never queued
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: if (i_dump_req) w_next = LOAD;
      LOAD: w_next = SEND;
      SEND: begin
        if (i_dump_ready) begin
          w_accept = 1'b1;
          w_next   = (r_cnt == c_LAST_IDX) ? IDLE : LOAD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Beat counter: advances on acceptance, wraps to 0 after the final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (r_cnt == c_LAST_IDX) ? '0 : r_cnt + AW'(1);
    end
  end

  // Beat capture: only LOAD updates the held beat so SEND stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (r_state == LOAD) begin
      r_idx  <= r_cnt;
      r_data <= i_cap_data;
      r_last <= (r_cnt == c_LAST_IDX);
    end
  end

  assign o_cnt        = r_cnt;
  assign o_dump_busy  = (r_state != IDLE);
  assign o_dump_valid = (r_state == SEND);
  assign o_dump_last  = r_last;
  assign o_dump_idx   = r_idx;
  assign o_dump_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-read-port register file with hard-wired zero register
//               and a handshaked full-register dump channel.
//               Optional macro REGFILE_BYPASS_EN forwards same-cycle write
//               data to read ports and to the dump capture path.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                dump_req,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_last
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_hit;
  logic [AW-1:0]   w_cnt;
  logic [XLEN-1:0] w_cap_data;

  // Index 0 is never written, so it reads back its reset value of zero
  assign w_wr_hit = we && (waddr != '0);

  // Storage array: async clear, single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_hit) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Independent combinational read ports
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = raddr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rdata[k*XLEN +: XLEN] = (w_wr_hit && (w_ra == waddr)) ? wdata : r_regs[w_ra];
`else
    assign rdata[k*XLEN +: XLEN] = r_regs[w_ra];
`endif
  end

  // Value presented to the dump sequencer during its LOAD cycle
`ifdef REGFILE_BYPASS_EN
  assign w_cap_data = (w_wr_hit && (waddr == w_cnt)) ? wdata : r_regs[w_cnt];
`else
  assign w_cap_data = r_regs[w_cnt];
`endif

  reg_file_dump_ctrl #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_dump_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_dump_req   (dump_req),
    .i_dump_ready (dump_ready),
    .i_cap_data   (w_cap_data),
    .o_cnt        (w_cnt),
    .o_dump_busy  (dump_busy),
    .o_dump_valid (dump_valid),
    .o_dump_last  (dump_last),
    .o_dump_idx   (dump_idx),
    .o_dump_data  (dump_data)
  );

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter NREGS, default 32: register count; power of two, at least 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports, 1 to 4.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port we, input, 1: write enable.
REQ-007 Port waddr, input, AW: write index.
REQ-008 Port wdata, input, XLEN: write data.
REQ-009 Port raddr, input, NRD*AW: packed read indices; port k occupies bits [k*AW +: AW].
REQ-010 Port rdata, output, NRD*XLEN: packed read data; port k occupies bits [k*XLEN +: XLEN].
REQ-011 Port dump_req, input, 1: single-cycle pulse that starts a register dump.
REQ-012 Port dump_busy, output, 1: dump in progress.
REQ-013 Port dump_valid, output, 1: dump beat valid.
REQ-014 Port dump_ready, input, 1: sink accepts the dump beat.
REQ-015 Port dump_idx, output, AW: index of the current beat.
REQ-016 Port dump_data, output, XLEN: register value of the current beat.
REQ-017 Port dump_last, output, 1: current beat is index NREGS-1.

Function
REQ-018 A write with we=1 and waddr!=0 SHALL update the register at waddr on the rising edge.
REQ-019 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-020 Reads SHALL be combinational; each port is independent and any ports may address the same index.
REQ-021 The dump FSM SHALL have states IDLE, LOAD and SEND.
REQ-022 IDLE to LOAD on dump_req=1; a dump_req outside IDLE SHALL be ignored and not queued.
REQ-023 LOAD SHALL capture the register at index cnt into dump_data, set dump_idx=cnt and go to SEND after exactly 1 cycle.
REQ-024 SEND SHALL hold dump_valid=1 with dump_idx, dump_data and dump_last stable until dump_valid and dump_ready are both 1.
REQ-025 On acceptance with cnt<NREGS-1, the FSM SHALL set cnt=cnt+1 and return to LOAD; with cnt=NREGS-1 it SHALL go to IDLE and set cnt=0.
REQ-026 dump_busy SHALL be 1 in LOAD and SEND, and 0 in IDLE.
REQ-027 Each beat SHALL carry the register value as of its LOAD cycle; writes after capture SHALL NOT alter the held beat.
REQ-028 A write in the same cycle as LOAD to the index being captured SHALL be seen in the captured value only when REGFILE_BYPASS_EN is defined; otherwise the old value is captured.
REQ-029 Normal writes and reads SHALL keep working during a dump with no stall; a dump always emits exactly NREGS beats.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all registers to 0.
REQ-031 rst_n=0 SHALL force the FSM to IDLE and set cnt=0, dump_valid=0, dump_busy=0, dump_last=0, dump_idx=0 and dump_data=0.
REQ-032 Reset mid-dump SHALL abort the dump with no further beats; a new dump_req is needed after release.

Configuration
REQ-033 With REGFILE_BYPASS_EN defined, a read port whose raddr equals waddr while we=1 and waddr!=0 SHALL return wdata in the same cycle; the REQ-028 capture also forwards.
REQ-034 Without REGFILE_BYPASS_EN, reads SHALL return the stored value and the new data SHALL be visible from the next cycle.

Structure
REQ-035 A shared package reg_file_pkg SHALL hold the default constants XLEN_DEF=32 and NREGS_DEF=32.
REQ-036 reg_file_pkg SHALL hold the dump FSM state enum dump_state_t (IDLE, LOAD, SEND).
REQ-037 The dump FSM SHALL be the sub-module reg_file_dump_ctrl, which generates cnt, the state and the handshake signals; the storage array and read muxes stay in reg_file_mp.

Verification
REQ-038 Reset then read all indices: every rdata = 0; write x0=32'hDEADBEEF, then read x0: result 0.
REQ-039 Write x5=32'h12345678 and read port 1 at index 5 in the same cycle: with the macro, 32'h12345678 that cycle; without it, old value 0 that cycle and 32'h12345678 the next cycle.
REQ-040 Registers i=1..31 written with i*3, dump_req pulsed, dump_ready held 1: 32 beats, idx 0..31, data 0,3,...,93, dump_last only on idx 31, dump_busy falls after the last beat.
REQ-041 dump_ready toggled 0,0,1 during a dump: each beat held stable while ready=0; no beat duplicated or dropped.
REQ-042 x7=32'hAAAA0000 is overwritten with 32'h5555FFFF while beat 7 is held unaccepted: beat carries 32'hAAAA0000; a later read of x7 returns 32'h5555FFFF.
REQ-043 rst_n asserted at beat 10, then a second dump_req pulsed during a dump: dump_valid=0 immediately and all registers read 0; the extra dump_req is ignored and the new dump emits exactly 32 beats.
